// File: rtl/track_ctrl.sv
// track_ctrl: frame-level sequencer for the single-pixel colour detector.
// Arms the detector once per CCD frame and captures the first hit of the frame.
// Hits are debounced across consecutive frames into a locked/lost status.
// A stable target position is published to downstream logic.
//
// State table
//   state | meaning
//   IDLE  | not tracking, waiting for start
//   WAIT  | between frames, waiting for new_frame
//   SCAN  | detector armed, capturing the first hit of the frame
//   EVAL  | one cycle: continuity/lock/loss bookkeeping for the frame just closed
//
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   start, stop           begin tracking / abort to IDLE (stop has priority)
//   new_frame, end_frame  CCD frame timing pulses
//   det_hit, det_X/Y_pos  detector first-match pulse and its position
//   arm                   detector enable, high exactly while in SCAN
//   locked                track status
//   o_X/Y_pos, pos_valid  published target position and its refresh pulse
//   lost                  pulse when an established lock is dropped
//   frame_cnt             count of evaluated frames, wraps
module track_ctrl #(
    parameter int POS_W       = 16,
    parameter int LOCK_FRAMES = 3,
    parameter int LOSS_FRAMES = 4,
    parameter int JITTER      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             new_frame,
    input  logic             end_frame,
    input  logic             det_hit,
    input  logic [POS_W-1:0] det_X_pos,
    input  logic [POS_W-1:0] det_Y_pos,
    output logic             arm,
    output logic             locked,
    output logic [POS_W-1:0] o_X_pos,
    output logic [POS_W-1:0] o_Y_pos,
    output logic             pos_valid,
    output logic             lost,
    output logic [15:0]      frame_cnt
);

    localparam int HC_W = $clog2(LOCK_FRAMES + 1);
    localparam int MC_W = $clog2(LOSS_FRAMES + 1);
    localparam logic [HC_W-1:0]  LOCK_C = HC_W'(LOCK_FRAMES);
    localparam logic [MC_W-1:0]  LOSS_C = MC_W'(LOSS_FRAMES);
    localparam logic [POS_W-1:0] JIT_C  = POS_W'(JITTER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2,
        EVAL = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [POS_W-1:0] cand_x, cand_y, last_x, last_y;
    logic [POS_W-1:0] cand_x_nxt, cand_y_nxt, last_x_nxt, last_y_nxt;
    logic             hit_seen, hit_seen_nxt;
    logic [HC_W-1:0]  hit_cnt, hit_cnt_nxt;
    logic [MC_W-1:0]  miss_cnt, miss_cnt_nxt, miss_inc;
    logic             locked_nxt, pos_valid_nxt, lost_nxt, arm_nxt;
    logic [POS_W-1:0] o_x_nxt, o_y_nxt;
    logic [15:0]      frame_cnt_nxt;
    logic             cont;

    function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                  input logic [POS_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cand_x_nxt    = cand_x;
        cand_y_nxt    = cand_y;
        last_x_nxt    = last_x;
        last_y_nxt    = last_y;
        hit_seen_nxt  = hit_seen;
        hit_cnt_nxt   = hit_cnt;
        miss_cnt_nxt  = miss_cnt;
        locked_nxt    = locked;
        o_x_nxt       = o_X_pos;
        o_y_nxt       = o_Y_pos;
        pos_valid_nxt = 1'b0;
        lost_nxt      = 1'b0;
        frame_cnt_nxt = frame_cnt;
        cont          = 1'b0;
        miss_inc      = miss_cnt + 1'b1;

        if (stop) begin
            // Abort is silent: no lost pulse, position and frame count are kept.
            state_nxt    = IDLE;
            locked_nxt   = 1'b0;
            hit_cnt_nxt  = '0;
            miss_cnt_nxt = '0;
            hit_seen_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state_nxt = WAIT;
                end
                WAIT: begin
                    if (new_frame) begin
                        state_nxt    = SCAN;
                        hit_seen_nxt = 1'b0;
                    end
                end
                SCAN: begin
                    if (det_hit && !hit_seen) begin
                        cand_x_nxt   = det_X_pos;
                        cand_y_nxt   = det_Y_pos;
                        hit_seen_nxt = 1'b1;
                    end
                    // A new_frame here stands in for a missing end_frame; it is
                    // consumed, so the frame it starts is not scanned.
                    if (end_frame || new_frame) state_nxt = EVAL;
                end
                EVAL: begin
                    state_nxt     = WAIT;
                    frame_cnt_nxt = frame_cnt + 16'd1;
                    if (hit_seen) begin
                        cont = (hit_cnt == '0) ||
                               ((abs_diff(cand_x, last_x) <= JIT_C) &&
                                (abs_diff(cand_y, last_y) <= JIT_C));
                        if (cont) begin
                            hit_cnt_nxt = (hit_cnt == LOCK_C) ? LOCK_C : hit_cnt + 1'b1;
                        end else begin
                            hit_cnt_nxt = HC_W'(1);
                            if (locked) begin
                                locked_nxt = 1'b0;
                                lost_nxt   = 1'b1;
                            end
                        end
                        last_x_nxt   = cand_x;
                        last_y_nxt   = cand_y;
                        miss_cnt_nxt = '0;
                        if (cont && (hit_cnt_nxt == LOCK_C)) begin
                            locked_nxt    = 1'b1;
                            o_x_nxt       = cand_x;
                            o_y_nxt       = cand_y;
                            pos_valid_nxt = 1'b1;
                        end
                    end else if (locked) begin
                        if (miss_inc == LOSS_C) begin
                            locked_nxt   = 1'b0;
                            lost_nxt     = 1'b1;
                            hit_cnt_nxt  = '0;
                            miss_cnt_nxt = '0;
                        end else begin
                            miss_cnt_nxt = miss_inc;
                        end
                    end else begin
                        hit_cnt_nxt = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        arm_nxt = (state_nxt == SCAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_x    <= '0;
            cand_y    <= '0;
            last_x    <= '0;
            last_y    <= '0;
            hit_seen  <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            arm       <= 1'b0;
            locked    <= 1'b0;
            o_X_pos   <= '0;
            o_Y_pos   <= '0;
            pos_valid <= 1'b0;
            lost      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            cand_x    <= cand_x_nxt;
            cand_y    <= cand_y_nxt;
            last_x    <= last_x_nxt;
            last_y    <= last_y_nxt;
            hit_seen  <= hit_seen_nxt;
            hit_cnt   <= hit_cnt_nxt;
            miss_cnt  <= miss_cnt_nxt;
            arm       <= arm_nxt;
            locked    <= locked_nxt;
            o_X_pos   <= o_x_nxt;
            o_Y_pos   <= o_y_nxt;
            pos_valid <= pos_valid_nxt;
            lost      <= lost_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_track_ctrl.sv
module tb_track_ctrl;

    logic        clk, rst, start, stop, new_frame, end_frame, det_hit;
    logic [15:0] det_X_pos, det_Y_pos;
    logic        arm, locked, pos_valid, lost;
    logic [15:0] o_X_pos, o_Y_pos, frame_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_lost;
        logic [15:0] x;
        logic [15:0] y;
        bit          lk;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];

    track_ctrl #(.POS_W(16), .LOCK_FRAMES(3), .LOSS_FRAMES(4), .JITTER(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .new_frame(new_frame), .end_frame(end_frame), .det_hit(det_hit),
        .det_X_pos(det_X_pos), .det_Y_pos(det_Y_pos),
        .arm(arm), .locked(locked), .o_X_pos(o_X_pos), .o_Y_pos(o_Y_pos),
        .pos_valid(pos_valid), .lost(lost), .frame_cnt(frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input bit is_lost, input logic [15:0] x, input logic [15:0] y,
                        input bit lk, input logic [15:0] fc);
        exp_t e;
        e.is_lost = is_lost; e.x = x; e.y = y; e.lk = lk; e.fc = fc;
        sb.push_back(e);
    endtask

    // Monitor: every pos_valid/lost pulse is matched against the next expected event.
    always @(negedge clk) begin
        if (!rst && (pos_valid || lost)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse pos_valid=%0b lost=%0b pos=(%0d,%0d) fc=%0d",
                         pos_valid, lost, o_X_pos, o_Y_pos, frame_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (pos_valid !== !e.is_lost || lost !== e.is_lost || o_X_pos !== e.x ||
                    o_Y_pos !== e.y || locked !== e.lk || frame_cnt !== e.fc) begin
                    failures++;
                    $display("FAIL event got pv=%0b lost=%0b pos=(%0d,%0d) lk=%0b fc=%0d exp lost=%0b pos=(%0d,%0d) lk=%0b fc=%0d",
                             pos_valid, lost, o_X_pos, o_Y_pos, locked, frame_cnt,
                             e.is_lost, e.x, e.y, e.lk, e.fc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 no hit, 1 one hit, 2 two hits, 3 hit coincident with end_frame
    task automatic frame(input int mode, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] x2, input logic [15:0] y2);
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        chk("arm_in_scan", arm, 1);
        if (mode == 1 || mode == 2) begin
            det_hit = 1'b1; det_X_pos = x; det_Y_pos = y; tick();
            if (mode == 2) begin
                det_X_pos = x2; det_Y_pos = y2; tick();
            end
            det_hit = 1'b0;
        end
        if (mode == 3) begin
            det_hit = 1'b1; det_X_pos = x; det_Y_pos = y;
        end
        end_frame = 1'b1; tick(); end_frame = 1'b0; det_hit = 1'b0;
        tick();
        chk("arm_after_eval", arm, 0);
    endtask

    initial begin
        rst = 1'b1; start = 0; stop = 0; new_frame = 0; end_frame = 0; det_hit = 0;
        det_X_pos = 0; det_Y_pos = 0;
        #22;
        chk("rst_arm", arm, 0);
        chk("rst_locked", locked, 0);
        chk("rst_pv_lost", {pos_valid, lost}, 0);
        chk("rst_pos", {o_X_pos, o_Y_pos}, 0);
        chk("rst_fc", frame_cnt, 0);
        tick(); rst = 1'b0; tick();

        // 1: lock after three continuous frames
        start = 1; tick(); start = 0;
        frame(1, 100, 50, 0, 0);
        frame(1, 104, 52, 0, 0);
        push(0, 110, 49, 1, 3);
        frame(1, 110, 49, 0, 0);
        tick();
        chk("t1_locked", locked, 1);
        chk("t1_pv_pulse_done", pos_valid, 0);

        // 2: four misses drop the lock
        frame(0, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0);
        chk("t2_still_locked", locked, 1);
        push(1, 110, 49, 0, 7);
        frame(0, 0, 0, 0, 0);
        chk("t2_unlocked", locked, 0);

        // 3: relock, jump away, relock at new place
        frame(1, 110, 49, 0, 0);
        frame(1, 110, 49, 0, 0);
        push(0, 110, 49, 1, 10);
        frame(1, 110, 49, 0, 0);
        push(1, 110, 49, 0, 11);
        frame(1, 300, 49, 0, 0);
        frame(1, 305, 50, 0, 0);
        chk("t3_not_yet", locked, 0);
        push(0, 298, 47, 1, 13);
        frame(1, 298, 47, 0, 0);

        // 4: first hit wins; hits coincident with end_frame count
        push(1, 298, 47, 0, 14);
        frame(2, 10, 10, 500, 500);
        frame(3, 12, 13, 0, 0);
        push(0, 14, 9, 1, 16);
        frame(3, 14, 9, 0, 0);
        chk("t4_locked", locked, 1);

        // 5: stop mid-SCAN while locked
        new_frame = 1; tick(); new_frame = 0;
        chk("t5_arm_scan", arm, 1);
        stop = 1; tick(); stop = 0;
        chk("t5_arm_off", arm, 0);
        chk("t5_unlocked", locked, 0);
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        new_frame = 1; tick(); new_frame = 0;
        chk("t5_idle_ignores_frame", arm, 0);
        det_hit = 1; end_frame = 1; tick(); det_hit = 0; end_frame = 0;
        tick();
        chk("t5_fc_hold", frame_cnt, 16);
        chk("t5_pos_hold", {o_X_pos, o_Y_pos}, {16'd14, 16'd9});
        start = 1; tick(); start = 0;
        frame(1, 14, 9, 0, 0);
        chk("t5_hitcnt_cleared", locked, 0);
        chk("t5_fc", frame_cnt, 17);

        // new_frame+end_frame together in WAIT; new_frame closing SCAN
        new_frame = 1; end_frame = 1; tick(); new_frame = 0; end_frame = 0;
        chk("both_pulses_arm", arm, 1);
        tick();
        chk("end_ignored_in_wait", arm, 1);
        new_frame = 1; tick(); new_frame = 0;
        tick();
        chk("nf_close_arm", arm, 0);
        tick();
        chk("nf_not_reused", arm, 0);
        chk("nf_close_fc", frame_cnt, 18);

        // 6: frame counter wrap, preset while idle
        stop = 1; tick(); stop = 0;
        force dut.frame_cnt = 16'hFFFE;
        tick();
        release dut.frame_cnt;
        start = 1; tick(); start = 0;
        frame(0, 0, 0, 0, 0);
        chk("t6_fc_ffff", frame_cnt, 16'hFFFF);
        frame(0, 0, 0, 0, 0);
        chk("t6_fc_wrap", frame_cnt, 16'h0000);
        frame(1, 7, 7, 0, 0);
        chk("t6_fc_one", frame_cnt, 16'h0001);

        // async reset during SCAN
        new_frame = 1; tick(); new_frame = 0;
        chk("t6_arm_scan", arm, 1);
        rst = 1'b1;
        #2;
        chk("arst_arm", arm, 0);
        chk("arst_locked", locked, 0);
        chk("arst_pos", {o_X_pos, o_Y_pos}, 0);
        chk("arst_fc", frame_cnt, 0);
        chk("arst_pulses", {pos_valid, lost}, 0);
        tick(); rst = 1'b0; tick(); tick();

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
